// File: rtl/alu_op_sequencer.sv
// Issue/collect stage in front of a 32-bit single-bit-shift ALU: holds operands
// for WAIT_CYC cycles per pass, iterates shifts, and returns result plus flags.
// Optional completed-op counter is enabled by defining ALU_SEQ_PERF_EN.
module alu_op_sequencer #(
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_illegal,
    output logic              busy,
    output logic [31:0]       op_count
);

    localparam logic [3:0] FN_SLA = 4'b0110;
    localparam logic [3:0] FN_SRA = 4'b0111;
    localparam logic [3:0] FN_SRL = 4'b1000;

    localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic [DATA_W-1:0] alu_a_q,      alu_a_d;
    logic [DATA_W-1:0] alu_b_q,      alu_b_d;
    logic [3:0]        alu_func_q,   alu_func_d;
    logic [4:0]        pass_q,       pass_d;
    logic [3:0]        wait_q,       wait_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_zero_q,   out_zero_d;
    logic              out_neg_q,    out_neg_d;
    logic              out_illegal_q, out_illegal_d;

    function automatic logic is_shift(input logic [3:0] f);
        return (f == FN_SLA) || (f == FN_SRA) || (f == FN_SRL);
    endfunction

    // State and datapath registers; rst abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= ZERO_W;
            alu_b_q       <= ZERO_W;
            alu_func_q    <= 4'd0;
            pass_q        <= 5'd0;
            wait_q        <= 4'd0;
            out_result_q  <= ZERO_W;
            out_zero_q    <= 1'b0;
            out_neg_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_func_q    <= alu_func_d;
            pass_q        <= pass_d;
            wait_q        <= wait_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_neg_q     <= out_neg_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_func_d    = alu_func_q;
        pass_d        = pass_q;
        wait_d        = wait_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_neg_d     = out_neg_q;
        out_illegal_d = out_illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_func > FN_SRL) begin
                        // Illegal op never touches the ALU operand registers.
                        out_result_d  = ZERO_W;
                        out_zero_d    = 1'b1;
                        out_neg_d     = 1'b0;
                        out_illegal_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        alu_func_d    = in_func;
                        out_illegal_d = 1'b0;
                        if (is_shift(in_func)) begin
                            if (in_b[4:0] == 5'd0) begin
                                out_result_d = in_a;
                                out_zero_d   = (in_a == ZERO_W);
                                out_neg_d    = in_a[DATA_W-1];
                                state_d      = ST_DONE;
                            end else begin
                                alu_a_d = in_a;
                                alu_b_d = ONE_W;
                                pass_d  = in_b[4:0];
                                wait_d  = WAIT_LOAD;
                                state_d = ST_EXEC;
                            end
                        end else begin
                            alu_a_d = in_a;
                            alu_b_d = in_b;
                            pass_d  = 5'd1;
                            wait_d  = WAIT_LOAD;
                            state_d = ST_EXEC;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (pass_q > 5'd1) begin
                    // Feed the partial shift result back for another pass.
                    alu_a_d = alu_result;
                    pass_d  = pass_q - 5'd1;
                    wait_d  = WAIT_LOAD;
                end else begin
                    out_result_d = alu_result;
                    out_zero_d   = (alu_result == ZERO_W);
                    out_neg_d    = alu_result[DATA_W-1];
                    pass_d       = 5'd0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] op_count_q, op_count_d;

    // Completed-op counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 32'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    // Count every drained result, illegal ops included.
    always_comb begin
        op_count_d = op_count_q;
        if ((state_q == ST_DONE) && out_ready) begin
            op_count_d = op_count_q + 32'd1;
        end else begin
            op_count_d = op_count_q;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 32'd0;
`endif

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_func    = alu_func_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_neg     = out_neg_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_func;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_illegal;
    logic        busy;
    logic [31:0] op_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];

    alu_op_sequencer #(.DATA_W(32), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_illegal(out_illegal),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: shift ops move by alu_b[0] bits.
    always_comb begin
        case (alu_func)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = ~alu_a;
            4'b0110: alu_result = alu_b[0] ? (alu_a << 1) : alu_a;
            4'b0111: alu_result = alu_b[0] ? 32'($signed(alu_a) >>> 1) : alu_a;
            4'b1000: alu_result = alu_b[0] ? (alu_a >> 1) : alu_a;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] res, input logic ill, input int lat);
        exp_t e;
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_func  = f;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = res;
            e.ill = ill;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency", n, e.lat);
        chk("out_result", out_result, e.res);
        chk("out_zero", {31'd0, out_zero}, {31'd0, (e.res == 32'd0)});
        chk("out_neg", {31'd0, out_neg}, {31'd0, e.res[31]});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("op_count_pending", op_count, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", out_result, e.res);
            chk("hold_zero", {31'd0, out_zero}, {31'd0, (e.res == 32'd0)});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef ALU_SEQ_PERF_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("op_count", op_count, exp_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_func   = 4'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_func", {28'd0, alu_func}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {29'd0, out_zero, out_neg, out_illegal}, 32'd0);
        chk("rst_op_count", op_count, 32'd0);

        issue(4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 1'b0, 2);
        collect(0);
        issue(4'b0001, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0, 2);
        collect(5);
        issue(4'b0111, 32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 62);
        collect(0);
        issue(4'b1000, 32'h8000_0000, 32'd31, 1'b1, 32'h0000_0001, 1'b0, 62);
        collect(0);
        issue(4'b0110, 32'd1, 32'd4, 1'b1, 32'h0000_0010, 1'b0, 8);
        collect(0);
        issue(4'b0110, 32'h4000_0000, 32'h21, 1'b1, 32'h8000_0000, 1'b0, 2);
        collect(0);
        issue(4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 1'b0, 2);
        collect(0);
        issue(4'b0011, 32'hF000_0000, 32'h0000_000F, 1'b1, 32'hF000_000F, 1'b0, 2);
        collect(0);
        issue(4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 1'b0, 2);
        collect(0);
        issue(4'b0101, 32'd0, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
        collect(0);
        issue(4'b0000, 32'h10, 32'h20, 1'b1, 32'h30, 1'b0, 2);
        collect(0);

        issue(4'b1111, 32'hDEAD_BEEF, 32'h5, 1'b1, 32'd0, 1'b1, 0);
        chk("illegal_alu_a", alu_a, 32'h10);
        chk("illegal_alu_b", alu_b, 32'h20);
        chk("illegal_alu_func", {28'd0, alu_func}, 32'd0);
        collect(0);

        issue(4'b0111, 32'h1234, 32'h20, 1'b1, 32'h1234, 1'b0, 0);
        collect(0);
        chk("illegal_cleared", {31'd0, out_illegal}, 32'd0);

        issue(4'b0110, 32'd1, 32'd10, 1'b0, 32'd0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef ALU_SEQ_PERF_EN
        exp_cnt = 32'd0;
`endif
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_b", alu_b, 32'd0);
        chk("abort_alu_func", {28'd0, alu_func}, 32'd0);
        chk("abort_op_count", op_count, exp_cnt);

        issue(4'b0000, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 2);
        collect(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
